// File: rtl/cpc_ga_pkg.sv
// +----------------------------------------------------------------------------+
// | cpc_ga_pkg: shared Gate Array port constants and decode strobe type         |
// | Rev 1.0                                                                     |
// +----------------------------------------------------------------------------+
`default_nettype none

package cpc_ga_pkg;

  localparam logic [1:0] GA_PORT_SEL    = 2'b01;
  localparam logic [1:0] RMR_FUNC       = 2'b10;
  localparam int         RMR_IRQCLR_BIT = 4;
  localparam int         R52_W          = 6;
  localparam logic [R52_W-1:0] R52_HALF = 6'd32;

  typedef struct packed {
    logic ack;         // first cycle of M1+IORQ
    logic io_wr;       // first cycle of a selected-port I/O write
    logic ack_active;  // M1+IORQ currently asserted on the bus
  } io_strobe_t;

endpackage

`default_nettype wire

// File: rtl/cpc_ga_irq_responder_if.sv
// +----------------------------------------------------------------------------+
// | cpc_ga_irq_responder_if: Z80 bus signals between CPU and port responder     |
// | Rev 1.0                                                                     |
// +----------------------------------------------------------------------------+
`default_nettype none

interface cpc_ga_irq_responder_if;
  logic        m1_n;
  logic        iorq_n;
  logic        wr_n;
  logic [15:0] a;
  logic [7:0]  din;
  logic        int_n;
  logic [7:0]  dout;
  logic        dout_oe;

  modport master (
    output m1_n, iorq_n, wr_n, a, din,
    input  int_n, dout, dout_oe
  );

  modport slave (
    input  m1_n, iorq_n, wr_n, a, din,
    output int_n, dout, dout_oe
  );
endinterface

`default_nettype wire

// File: rtl/z80_io_cycle_decode.sv
// +----------------------------------------------------------------------------+
// | z80_io_cycle_decode: edge-detected ack and port-write strobes for Z80 I/O  |
// | Rev 1.0                                                                     |
// +----------------------------------------------------------------------------+
`default_nettype none

module z80_io_cycle_decode
  import cpc_ga_pkg::*;
#(
  parameter logic [1:0] PORT_SEL = GA_PORT_SEL
) (
  input  wire logic       clk,
  input  wire logic       reset_n,
  input  wire logic       m1_n,
  input  wire logic       iorq_n,
  input  wire logic       wr_n,
  input  wire logic [1:0] a_hi,
  output io_strobe_t      strb
);

  logic ack_cond;
  logic wr_cond;
  logic ack_cond_q;
  logic wr_cond_q;

  assign ack_cond = !m1_n && !iorq_n;
  assign wr_cond  = !iorq_n && !wr_n && m1_n && (a_hi == PORT_SEL);

  // Reset to "asserted" so a bus cycle straddling reset never yields a strobe.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ack_cond_q <= 1'b1;
      wr_cond_q  <= 1'b1;
    end else begin
      ack_cond_q <= ack_cond;
      wr_cond_q  <= wr_cond;
    end
  end

  assign strb.ack        = ack_cond && !ack_cond_q;
  assign strb.io_wr      = wr_cond && !wr_cond_q;
  assign strb.ack_active = ack_cond;

endmodule

`default_nettype wire

// File: rtl/cpc_ga_irq_responder.sv
// +----------------------------------------------------------------------------+
// | cpc_ga_irq_responder: Gate Array raster interrupt counter and ack responder|
// | Rev 1.0                                                                     |
// +----------------------------------------------------------------------------+
`default_nettype none

module cpc_ga_irq_responder
  import cpc_ga_pkg::*;
#(
  parameter int         LINES_PER_INT = 52,
  parameter int         VSYNC_DELAY   = 2,
  parameter logic [7:0] ACK_VECTOR    = 8'hFF
) (
  input  wire logic                clk,
  input  wire logic                reset_n,
  cpc_ga_irq_responder_if.slave    bus,
  input  wire logic                hsync,
  input  wire logic                vsync,
  output logic [R52_W-1:0]         r52
);

  localparam int DLY_W = 4;

  io_strobe_t       strb;
  logic             hsync_q;
  logic             vsync_q;
  logic [DLY_W-1:0] dly;
  logic             int_n_q;

  logic             hs_fall;
  logic             vs_rise;
  logic [R52_W:0]   r52_inc;
  logic             wrap;
  logic             resync_hit;
  logic             raise;
  logic             ga_clr;
  logic [R52_W-1:0] r52_nx;
  logic             int_n_nx;
  logic [DLY_W-1:0] dly_nx;
  logic             unused_bits;

  z80_io_cycle_decode #(
    .PORT_SEL (GA_PORT_SEL)
  ) u_decode (
    .clk     (clk),
    .reset_n (reset_n),
    .m1_n    (bus.m1_n),
    .iorq_n  (bus.iorq_n),
    .wr_n    (bus.wr_n),
    .a_hi    (bus.a[15:14]),
    .strb    (strb)
  );

  assign unused_bits = &{1'b0, bus.a[13:0], bus.din[5], bus.din[3:0]};

  assign hs_fall    = hsync_q && !hsync;
  assign vs_rise    = !vsync_q && vsync;
  assign r52_inc    = {1'b0, r52} + 1'b1;
  assign wrap       = hs_fall && (r52_inc == (R52_W+1)'(LINES_PER_INT));
  // A fresh VSYNC edge restarts the count, so it cannot also complete it.
  assign resync_hit = hs_fall && !vs_rise && (dly == DLY_W'(1));
  assign raise      = wrap || (resync_hit && (r52 >= R52_HALF));
  assign ga_clr     = strb.io_wr && (bus.din[7:6] == RMR_FUNC) && bus.din[RMR_IRQCLR_BIT];

  always_comb begin
    r52_nx   = r52;
    int_n_nx = int_n_q;
    dly_nx   = dly;

    if (vs_rise) begin
      dly_nx = DLY_W'(VSYNC_DELAY);
    end else if (hs_fall && (dly != '0)) begin
      dly_nx = dly - 1'b1;
    end

    if (ga_clr) begin
      r52_nx   = '0;
      int_n_nx = 1'b1;
    end else if (strb.ack) begin
      // A raise landing on the ack edge must survive the acknowledge.
      int_n_nx = !raise;
      r52_nx   = (wrap || resync_hit) ? '0 : (r52 & 6'h1F);
    end else begin
      if (raise) begin
        int_n_nx = 1'b0;
      end
      if (hs_fall) begin
        r52_nx = (wrap || resync_hit) ? '0 : r52_inc[R52_W-1:0];
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      hsync_q <= 1'b0;
      vsync_q <= 1'b0;
      dly     <= '0;
      r52     <= '0;
      int_n_q <= 1'b1;
    end else begin
      hsync_q <= hsync;
      vsync_q <= vsync;
      dly     <= dly_nx;
      r52     <= r52_nx;
      int_n_q <= int_n_nx;
    end
  end

  assign bus.int_n   = int_n_q;
  assign bus.dout_oe = strb.ack_active;
  assign bus.dout    = strb.ack_active ? ACK_VECTOR : 8'hFF;

endmodule

`default_nettype wire

// File: tb/tb_cpc_ga_irq_responder.sv
// +----------------------------------------------------------------------------+
// | tb_cpc_ga_irq_responder: directed vectors with hand-computed expectations  |
// | Rev 1.0                                                                     |
// +----------------------------------------------------------------------------+
`default_nettype none

module tb_cpc_ga_irq_responder;

  logic       clk;
  logic       reset_n;
  logic       hsync;
  logic       vsync;
  logic [5:0] r52;

  int n_cmp;
  int n_bad;

  cpc_ga_irq_responder_if bus_if();

  cpc_ga_irq_responder #(
    .LINES_PER_INT (52),
    .VSYNC_DELAY   (2),
    .ACK_VECTOR    (8'hFF)
  ) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus_if.slave),
    .hsync   (hsync),
    .vsync   (vsync),
    .r52     (r52)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input int obs, input int exp);
    n_cmp++;
    if (obs != exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Inputs change and outputs are sampled 1 time unit after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic hs_pulse(input int n);
    for (int i = 0; i < n; i++) begin
      hsync = 1'b1;
      tick();
      hsync = 1'b0;
      tick();
    end
  endtask

  task automatic ack_cycle();
    bus_if.m1_n   = 1'b0;
    bus_if.iorq_n = 1'b0;
    tick();
    tick();
    bus_if.m1_n   = 1'b1;
    bus_if.iorq_n = 1'b1;
    tick();
  endtask

  task automatic ga_write(input logic [15:0] addr, input logic [7:0] data);
    bus_if.a      = addr;
    bus_if.din    = data;
    bus_if.wr_n   = 1'b0;
    bus_if.iorq_n = 1'b0;
    tick();
    tick();
    bus_if.iorq_n = 1'b1;
    bus_if.wr_n   = 1'b1;
    tick();
  endtask

  initial begin
    n_cmp = 0;
    n_bad = 0;
    reset_n       = 1'b0;
    hsync         = 1'b0;
    vsync         = 1'b0;
    bus_if.m1_n   = 1'b1;
    bus_if.iorq_n = 1'b1;
    bus_if.wr_n   = 1'b1;
    bus_if.a      = 16'h0000;
    bus_if.din    = 8'h00;
    tick();
    tick();
    reset_n = 1'b1;
    tick();

    chk("rst_int_n", int'(bus_if.int_n), 1);
    chk("rst_dout", int'(bus_if.dout), 8'hFF);
    chk("rst_dout_oe", int'(bus_if.dout_oe), 0);
    chk("rst_r52", int'(r52), 0);

    // Free run
    hs_pulse(51);
    chk("free51_r52", int'(r52), 51);
    chk("free51_int_n", int'(bus_if.int_n), 1);
    hs_pulse(1);
    chk("free52_int_n", int'(bus_if.int_n), 0);
    chk("free52_r52", int'(r52), 0);
    hs_pulse(52);
    chk("free104_int_n", int'(bus_if.int_n), 0);
    chk("free104_r52", int'(r52), 0);

    // Acknowledge held for three clocks
    bus_if.m1_n   = 1'b0;
    bus_if.iorq_n = 1'b0;
    #1;
    chk("ack0_dout_oe", int'(bus_if.dout_oe), 1);
    chk("ack0_dout", int'(bus_if.dout), 8'hFF);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("ack_dout_oe", int'(bus_if.dout_oe), 1);
      chk("ack_dout", int'(bus_if.dout), 8'hFF);
    end
    chk("ack_int_n", int'(bus_if.int_n), 1);
    bus_if.m1_n   = 1'b1;
    bus_if.iorq_n = 1'b1;
    #1;
    chk("ack_end_dout_oe", int'(bus_if.dout_oe), 0);
    tick();

    hs_pulse(40);
    chk("pre_ack_r52", int'(r52), 40);
    ack_cycle();
    chk("ack40_r52", int'(r52), 8);

    // VSYNC resync above half frame
    hs_pulse(27);
    chk("vs_pre_r52", int'(r52), 35);
    vsync = 1'b1;
    tick();
    hs_pulse(1);
    chk("vs_hs1_r52", int'(r52), 36);
    hs_pulse(1);
    chk("vs35_int_n", int'(bus_if.int_n), 0);
    chk("vs35_r52", int'(r52), 0);
    vsync = 1'b0;
    tick();
    ack_cycle();
    chk("vs_ack_int_n", int'(bus_if.int_n), 1);

    // VSYNC resync below half frame
    hs_pulse(20);
    vsync = 1'b1;
    tick();
    hs_pulse(2);
    chk("vs20_int_n", int'(bus_if.int_n), 1);
    chk("vs20_r52", int'(r52), 0);
    vsync = 1'b0;
    tick();

    // GA write clear
    hs_pulse(52);
    chk("ga_pre_int_n", int'(bus_if.int_n), 0);
    hs_pulse(30);
    ga_write(16'h7F00, 8'h90);
    chk("ga90_int_n", int'(bus_if.int_n), 1);
    chk("ga90_r52", int'(r52), 0);
    hs_pulse(52);
    hs_pulse(5);
    ga_write(16'h7F00, 8'h80);
    chk("ga80_int_n", int'(bus_if.int_n), 0);
    chk("ga80_r52", int'(r52), 5);
    ga_write(16'hBF00, 8'h90);
    chk("gaBF_int_n", int'(bus_if.int_n), 0);
    chk("gaBF_r52", int'(r52), 5);

    // Ack strobe on the same edge as the 52nd falling HSYNC
    hs_pulse(46);
    chk("col_pre_r52", int'(r52), 51);
    hsync = 1'b1;
    tick();
    hsync         = 1'b0;
    bus_if.m1_n   = 1'b0;
    bus_if.iorq_n = 1'b0;
    tick();
    chk("col_int_n", int'(bus_if.int_n), 0);
    chk("col_r52", int'(r52), 0);
    bus_if.m1_n   = 1'b1;
    bus_if.iorq_n = 1'b1;
    tick();
    chk("col_after_int_n", int'(bus_if.int_n), 0);

    // Reset during an acknowledge cycle
    bus_if.m1_n   = 1'b0;
    bus_if.iorq_n = 1'b0;
    #1;
    reset_n = 1'b0;
    #1;
    chk("mrst_int_n", int'(bus_if.int_n), 1);
    chk("mrst_r52", int'(r52), 0);
    tick();
    reset_n = 1'b1;
    tick();
    chk("mrst_dout_oe", int'(bus_if.dout_oe), 1);
    hs_pulse(52);
    chk("mrst_noack_int_n", int'(bus_if.int_n), 0);
    chk("mrst_noack_r52", int'(r52), 0);
    bus_if.m1_n   = 1'b1;
    bus_if.iorq_n = 1'b1;
    #1;
    chk("mrst_end_dout_oe", int'(bus_if.dout_oe), 0);
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

`default_nettype wire
